// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies one 160-byte source page into the on-chip OAM store,
// locking out CPU access while the copy runs; the PPU read port is never blocked.
module oam_dma_engine #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4,
  parameter int OAM_BYTES       = 160
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trig,
  input  logic [7:0]  trig_page,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  cpu_oam_addr,
  input  logic        cpu_oam_we,
  input  logic [7:0]  cpu_oam_wdata,
  output logic [7:0]  cpu_oam_rdata,
  input  logic [7:0]  ppu_oam_addr,
  output logic [7:0]  ppu_oam_rdata
);

  localparam int PW = $clog2(CYCLES_PER_BYTE);
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [PW-1:0] PACE_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] PACE_WRITE = PW'(1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST   = 8'(OAM_BYTES - 1);
  localparam logic [8:0]    N_BYTES    = 9'(OAM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_XFER} state_t;

  state_t         r_state;
  logic [7:0]     r_page;
  logic [7:0]     r_index;
  logic [PW-1:0]  r_pace;
  logic [DW-1:0]  r_delay;
  logic           r_busy;
  logic           r_done;
  logic           r_src_rd;
  logic [15:0]    r_src_addr;
  logic [7:0]     r_cpu_rdata;
  logic [7:0]     r_ppu_rdata;
  logic [7:0]     r_oam [0:OAM_BYTES-1];

  logic [7:0]     w_page_fold;
  logic           w_cpu_in_range;
  logic           w_ppu_in_range;
  logic           w_dma_we;
  logic           w_cpu_we;
  logic           w_wr_en;
  logic [7:0]     w_wr_addr;
  logic [7:0]     w_wr_data;

  // Pages E0-FF are echo RAM and alias C0-DF.
  assign w_page_fold    = (trig_page[7:5] == 3'b111) ? {trig_page[7:6], 1'b0, trig_page[4:0]}
                                                     : trig_page;
  assign w_cpu_in_range = ({1'b0, cpu_oam_addr} < N_BYTES);
  assign w_ppu_in_range = ({1'b0, ppu_oam_addr} < N_BYTES);
  assign w_dma_we       = (r_state == S_XFER) && (r_pace == PACE_WRITE);
  assign w_cpu_we       = cpu_oam_we && !r_busy && w_cpu_in_range;
  assign w_wr_en        = resetn && (w_dma_we || w_cpu_we);
  assign w_wr_addr      = w_dma_we ? r_index : cpu_oam_addr;
  assign w_wr_data      = w_dma_we ? src_data : cpu_oam_wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_page     <= 8'h00;
      r_index    <= 8'h00;
      r_pace     <= '0;
      r_delay    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_src_rd   <= 1'b0;
      r_src_addr <= 16'h0000;
    end else begin
      r_done   <= 1'b0;
      r_src_rd <= 1'b0;
      if (trig) begin
        // A trigger always (re)starts from the top, abandoning any copy in flight.
        r_page  <= w_page_fold;
        r_index <= 8'h00;
        r_delay <= '0;
        r_pace  <= '0;
        r_busy  <= 1'b1;
        r_state <= S_DELAY;
      end else begin
        case (r_state)
          S_IDLE: begin
          end
          S_DELAY: begin
            if (r_delay == DELAY_LAST) begin
              r_state    <= S_XFER;
              r_pace     <= '0;
              r_src_rd   <= 1'b1;
              r_src_addr <= {r_page, r_index};
            end else begin
              r_delay <= r_delay + 1'b1;
            end
          end
          S_XFER: begin
            if (r_pace == PACE_LAST) begin
              r_pace <= '0;
              if (r_index == IDX_LAST) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_index    <= r_index + 8'd1;
                r_src_rd   <= 1'b1;
                r_src_addr <= {r_page, r_index + 8'd1};
              end
            end else begin
              r_pace <= r_pace + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Single write port; DMA and CPU writes are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_oam[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cpu_rdata <= 8'h00;
      r_ppu_rdata <= 8'h00;
    end else begin
      r_cpu_rdata <= (r_busy || !w_cpu_in_range) ? 8'hFF : r_oam[cpu_oam_addr];
      r_ppu_rdata <= w_ppu_in_range ? r_oam[ppu_oam_addr] : 8'h00;
    end
  end

  assign src_addr      = r_src_addr;
  assign src_rd        = r_src_rd;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cpu_oam_rdata = r_cpu_rdata;
  assign ppu_oam_rdata = r_ppu_rdata;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: copy, echo fold, CPU lockout, retrigger,
// mid-transfer reset and concurrent PPU reads.
module tb_oam_dma_engine;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        trig = 1'b0;
  logic [7:0]  trig_page = 8'h00;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data = 8'h00;
  logic        busy;
  logic        done;
  logic [7:0]  cpu_oam_addr = 8'h00;
  logic        cpu_oam_we = 1'b0;
  logic [7:0]  cpu_oam_wdata = 8'h00;
  logic [7:0]  cpu_oam_rdata;
  logic [7:0]  ppu_oam_addr = 8'h00;
  logic [7:0]  ppu_oam_rdata;

  always #5 clk = ~clk;

  // Synchronous source memory: byte at {p,k} is k ^ p ^ 0x9B (page C1 gives k ^ 0x5A).
  always @(posedge clk) begin
    if (src_rd) src_data <= src_addr[7:0] ^ src_addr[15:8] ^ 8'h9B;
  end

  oam_dma_engine dut (
    .clk(clk), .resetn(resetn), .trig(trig), .trig_page(trig_page),
    .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
    .busy(busy), .done(done),
    .cpu_oam_addr(cpu_oam_addr), .cpu_oam_we(cpu_oam_we),
    .cpu_oam_wdata(cpu_oam_wdata), .cpu_oam_rdata(cpu_oam_rdata),
    .ppu_oam_addr(ppu_oam_addr), .ppu_oam_rdata(ppu_oam_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cycnum = 0;
  int t_trig = 0;
  int fcount, first_cyc, last_cyc, gap_err, addr_err, done_cnt;
  logic [15:0] first_addr, last_addr;
  logic [7:0]  exp_page;

  function automatic logic [7:0] pdat(input logic [7:0] p, input int k);
    return 8'(k) ^ p ^ 8'h9B;
  endfunction

  function automatic logic [7:0] old_dat(input int k);
    return 8'(k + 8'h30);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and log fetch/done activity seen in the new cycle.
  task automatic cyc();
    @(negedge clk);
    cycnum++;
    if (done === 1'b1) done_cnt++;
    if (src_rd === 1'b1) begin
      fcount++;
      if (fcount == 1) begin
        first_addr = src_addr;
        first_cyc  = cycnum;
      end else if (cycnum - last_cyc != 4) begin
        gap_err++;
      end
      if (src_addr !== {exp_page, 8'(fcount - 1)}) addr_err++;
      last_addr = src_addr;
      last_cyc  = cycnum;
    end
  endtask

  task automatic start_trig(input logic [7:0] p);
    trig = 1'b1;
    trig_page = p;
    t_trig = cycnum;
    fcount = 0; gap_err = 0; addr_err = 0; done_cnt = 0;
    first_addr = 16'h0; last_addr = 16'h0; first_cyc = 0; last_cyc = 0;
    cyc();
    trig = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      cyc();
    end
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    cpu_oam_addr = a;
    cyc();
    d = cpu_oam_rdata;
  endtask

  initial begin
    int n;
    logic [7:0] d;

    fcount = 0; gap_err = 0; addr_err = 0; done_cnt = 0; exp_page = 8'h00;
    cyc();
    cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_src_rd", src_rd, 1'b0);
    chk("rst_src_addr", src_addr, 16'h0000);
    chk("rst_cpu_rdata", cpu_oam_rdata, 8'h00);
    chk("rst_ppu_rdata", ppu_oam_rdata, 8'h00);
    resetn = 1'b1;

    // Preload OAM with known "old" contents through the CPU port.
    for (int k = 0; k < 160; k++) begin
      cpu_oam_addr = 8'(k);
      cpu_oam_wdata = old_dat(k);
      cpu_oam_we = 1'b1;
      cyc();
    end
    cpu_oam_we = 1'b0;
    cpu_read(8'h05, d);
    chk("preload_rd5", d, 8'h35);
    cpu_read(8'hA5, d);
    chk("idle_oob_cpu", d, 8'hFF);

    // Basic copy from page C1 with lockout and PPU probes along the way.
    exp_page = 8'hC1;
    ppu_oam_addr = 8'h03;
    cpu_oam_addr = 8'h10;
    start_trig(8'hC1);
    chk("busy_t1", busy, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (n == 19) chk("ppu_before_write", ppu_oam_rdata, old_dat(3));
      if (n == 20) begin
        chk("ppu_after_write", ppu_oam_rdata, pdat(8'hC1, 3));
        cpu_oam_we = 1'b1;
        cpu_oam_wdata = 8'h33;
        ppu_oam_addr = 8'hA0;
      end
      if (n == 21) begin
        cpu_oam_we = 1'b0;
        chk("cpu_read_locked", cpu_oam_rdata, 8'hFF);
        chk("ppu_oob_busy", ppu_oam_rdata, 8'h00);
        ppu_oam_addr = 8'd150;
      end
      if (n == 22) chk("ppu_old_150", ppu_oam_rdata, old_dat(150));
      cyc();
    end
    chk("copy_busy_cycles", 16'(n), 16'd644);
    chk("copy_done_pulse", done, 1'b1);
    chk("copy_fetch_count", 16'(fcount), 16'd160);
    chk("copy_first_addr", first_addr, 16'hC100);
    chk("copy_last_addr", last_addr, 16'hC19F);
    chk("copy_first_latency", 16'(first_cyc - t_trig), 16'd5);
    chk("copy_gap_err", 16'(gap_err), 16'd0);
    chk("copy_addr_err", 16'(addr_err), 16'd0);
    cyc();
    chk("copy_done_one_cycle", done, 1'b0);
    for (int k = 0; k < 160; k++) begin
      cpu_read(8'(k), d);
      chk($sformatf("copy_byte_%0d", k), d, pdat(8'hC1, k));
    end
    cpu_read(8'h10, d);
    chk("lockout_write_dropped", d, 8'h4A);
    cpu_read(8'hA5, d);
    chk("after_oob_cpu", d, 8'hFF);

    // Echo fold, plus a CPU write accepted in the trigger cycle.
    exp_page = 8'hC2;
    cpu_oam_addr = 8'h20;
    cpu_oam_wdata = 8'h77;
    cpu_oam_we = 1'b1;
    ppu_oam_addr = 8'h20;
    start_trig(8'hE2);
    cpu_oam_we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (n == 10) chk("trig_cycle_cpu_write", ppu_oam_rdata, 8'h77);
      cyc();
    end
    chk("echo_busy_cycles", 16'(n), 16'd644);
    chk("echo_first_addr", first_addr, 16'hC200);
    chk("echo_last_addr", last_addr, 16'hC29F);
    chk("echo_fetch_count", 16'(fcount), 16'd160);
    chk("echo_done_count", 16'(done_cnt), 16'd1);
    chk("echo_addr_err", 16'(addr_err), 16'd0);
    cpu_read(8'h20, d);
    chk("echo_byte_20", d, pdat(8'hC2, 32));

    // Retrigger: C0 then C3 after 100 clocks.
    exp_page = 8'hC0;
    start_trig(8'hC0);
    repeat (99) cyc();
    chk("retrig_busy_mid", busy, 1'b1);
    chk("retrig_no_early_done", 16'(done_cnt), 16'd0);
    exp_page = 8'hC3;
    start_trig(8'hC3);
    wait_idle(n);
    chk("retrig_busy_cycles", 16'(n), 16'd644);
    chk("retrig_first_addr", first_addr, 16'hC300);
    chk("retrig_first_latency", 16'(first_cyc - t_trig), 16'd5);
    chk("retrig_fetch_count", 16'(fcount), 16'd160);
    chk("retrig_addr_err", 16'(addr_err), 16'd0);
    repeat (3) cyc();
    chk("retrig_done_count", 16'(done_cnt), 16'd1);
    cpu_read(8'h00, d);
    chk("retrig_byte_0", d, pdat(8'hC3, 0));
    cpu_read(8'h50, d);
    chk("retrig_byte_50h", d, pdat(8'hC3, 80));
    cpu_read(8'h9F, d);
    chk("retrig_byte_9fh", d, pdat(8'hC3, 159));

    // Reset after 50 bytes have been written.
    exp_page = 8'hC1;
    start_trig(8'hC1);
    repeat (203) cyc();
    chk("rstmid_fetches", 16'(fcount), 16'd50);
    resetn = 1'b0;
    cyc();
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_src_rd", src_rd, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_src_addr", src_addr, 16'h0000);
    cyc();
    resetn = 1'b1;
    cyc();
    cyc();
    chk("rstmid_no_done", 16'(done_cnt), 16'd0);
    chk("rstmid_no_more_fetch", 16'(fcount), 16'd50);
    for (int k = 0; k < 160; k++) begin
      cpu_read(8'(k), d);
      chk($sformatf("rstmid_byte_%0d", k), d, (k < 50) ? pdat(8'hC1, k) : pdat(8'hC3, k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
